// File: rtl/itch_msg_parser.sv
// ITCH 5.0 Add/Delete/Executed message parser: byte-serial field capture with length checking.
// Optional statistics counters are compiled in when ITCH_PARSER_STATS_EN is defined.
module itch_msg_parser #(
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic [7:0]            dataIn,
  input  logic                  validIn,
  input  logic                  lastIn,
  output logic                  addValidOut,
  output logic                  delValidOut,
  output logic                  execValidOut,
  output logic [63:0]           refNumOut,
  output logic [15:0]           locateOut,
  output logic [31:0]           priceOut,
  output logic [31:0]           sharesOut,
  output logic                  buySellOut,
  output logic                  errOut,
  output logic [STAT_WIDTH-1:0] msgCntOut,
  output logic [STAT_WIDTH-1:0] errCntOut
);

  typedef enum logic [1:0] {IDLE, PARSE, SKIP} parserStateT;
  typedef enum logic [1:0] {MSG_ADD, MSG_DEL, MSG_EXEC} msgKindT;

  parserStateT state;
  msgKindT     kind;
  logic [5:0]  byteCnt;
  logic        skipErr;

  logic [15:0] locateCap, locateNxt;
  logic [63:0] refCap, refNxt;
  logic [31:0] sharesCap, sharesNxt;
  logic [31:0] priceCap, priceNxt;
  logic        sideCap, sideNxt;
  logic [5:0]  lastIdx;
  logic        atLast;

  always_comb begin
    lastIdx = 6'd35;
    unique case (kind)
      MSG_ADD:  lastIdx = 6'd35;
      MSG_DEL:  lastIdx = 6'd18;
      MSG_EXEC: lastIdx = 6'd30;
      default:  lastIdx = 6'd35;
    endcase
  end

  assign atLast = (byteCnt == lastIdx);

  // The *Nxt values already include the byte being accepted, so the final
  // byte of a message (e.g. price LSB of an Add) reaches the outputs with its pulse.
  always_comb begin
    locateNxt = locateCap;
    refNxt    = refCap;
    sharesNxt = sharesCap;
    priceNxt  = priceCap;
    sideNxt   = sideCap;
    if (state == PARSE && validIn) begin
      if (byteCnt >= 6'd1 && byteCnt <= 6'd2)
        locateNxt = {locateCap[7:0], dataIn};
      if (byteCnt >= 6'd11 && byteCnt <= 6'd18)
        refNxt = {refCap[55:0], dataIn};
      if (kind == MSG_ADD) begin
        if (byteCnt == 6'd19)
          sideNxt = (dataIn == 8'h42);
        if (byteCnt >= 6'd20 && byteCnt <= 6'd23)
          sharesNxt = {sharesCap[23:0], dataIn};
        if (byteCnt >= 6'd32 && byteCnt <= 6'd35)
          priceNxt = {priceCap[23:0], dataIn};
      end
      if (kind == MSG_EXEC && byteCnt >= 6'd19 && byteCnt <= 6'd22)
        sharesNxt = {sharesCap[23:0], dataIn};
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state        <= IDLE;
      kind         <= MSG_ADD;
      byteCnt      <= '0;
      skipErr      <= 1'b0;
      locateCap    <= '0;
      refCap       <= '0;
      sharesCap    <= '0;
      priceCap     <= '0;
      sideCap      <= 1'b0;
      addValidOut  <= 1'b0;
      delValidOut  <= 1'b0;
      execValidOut <= 1'b0;
      errOut       <= 1'b0;
      refNumOut    <= '0;
      locateOut    <= '0;
      priceOut     <= '0;
      sharesOut    <= '0;
      buySellOut   <= 1'b0;
    end else begin
      addValidOut  <= 1'b0;
      delValidOut  <= 1'b0;
      execValidOut <= 1'b0;
      errOut       <= 1'b0;
      locateCap    <= locateNxt;
      refCap       <= refNxt;
      sharesCap    <= sharesNxt;
      priceCap     <= priceNxt;
      sideCap      <= sideNxt;
      if (validIn) begin
        unique case (state)
          IDLE: begin
            byteCnt <= 6'd1;
            if (dataIn == 8'h41 || dataIn == 8'h44 || dataIn == 8'h45) begin
              kind <= (dataIn == 8'h41) ? MSG_ADD : (dataIn == 8'h44) ? MSG_DEL : MSG_EXEC;
              if (lastIn) errOut <= 1'b1;
              else        state  <= PARSE;
            end else if (!lastIn) begin
              state   <= SKIP;
              skipErr <= 1'b0;
            end
          end
          PARSE: begin
            byteCnt <= byteCnt + 6'd1;
            if (lastIn) begin
              state <= IDLE;
              if (atLast) begin
                locateOut <= locateNxt;
                refNumOut <= refNxt;
                unique case (kind)
                  MSG_ADD: begin
                    addValidOut <= 1'b1;
                    priceOut    <= priceNxt;
                    sharesOut   <= sharesNxt;
                    buySellOut  <= sideNxt;
                  end
                  MSG_DEL: delValidOut <= 1'b1;
                  MSG_EXEC: begin
                    execValidOut <= 1'b1;
                    sharesOut    <= sharesNxt;
                  end
                  default: ;
                endcase
              end else begin
                errOut <= 1'b1;
              end
            end else if (atLast) begin
              state   <= SKIP;
              skipErr <= 1'b1;
            end
          end
          SKIP: begin
            if (lastIn) begin
              state  <= IDLE;
              errOut <= skipErr;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ITCH_PARSER_STATS_EN
  logic [STAT_WIDTH-1:0] msgCnt, errCnt;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      msgCnt <= '0;
      errCnt <= '0;
    end else begin
      if ((addValidOut || delValidOut || execValidOut) && msgCnt != '1)
        msgCnt <= msgCnt + 1'b1;
      if (errOut && errCnt != '1)
        errCnt <= errCnt + 1'b1;
    end
  end

  assign msgCntOut = msgCnt;
  assign errCntOut = errCnt;
`else
  assign msgCntOut = '0;
  assign errCntOut = '0;
`endif

endmodule

// File: tb/tb_itch_msg_parser.sv
// Bench for itch_msg_parser: directed and randomized messages checked against a byte-array reference model.
module tb_itch_msg_parser;

  logic        clkIn = 1'b0;
  logic        rstNIn;
  logic [7:0]  dataIn;
  logic        validIn;
  logic        lastIn;
  logic        addValidOut, delValidOut, execValidOut, buySellOut, errOut;
  logic [63:0] refNumOut;
  logic [15:0] locateOut;
  logic [31:0] priceOut, sharesOut;
  logic [31:0] msgCntOut, errCntOut;

  itch_msg_parser #(.STAT_WIDTH(32)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn), .dataIn(dataIn), .validIn(validIn), .lastIn(lastIn),
    .addValidOut(addValidOut), .delValidOut(delValidOut), .execValidOut(execValidOut),
    .refNumOut(refNumOut), .locateOut(locateOut), .priceOut(priceOut), .sharesOut(sharesOut),
    .buySellOut(buySellOut), .errOut(errOut), .msgCntOut(msgCntOut), .errCntOut(errCntOut)
  );

  always #5 clkIn = ~clkIn;

  int unsigned nChecks = 0;
  int unsigned nErrors = 0;

  logic [7:0]  msg[$];
  logic [15:0] expLocate;
  logic [63:0] expRef;
  logic [31:0] expPrice, expShares;
  logic        expSide;
  int unsigned expMsgCnt, expErrCnt;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    expLocate = '0; expRef = '0; expPrice = '0; expShares = '0; expSide = 1'b0;
    expMsgCnt = 0; expErrCnt = 0;
  endtask

  function automatic logic [63:0] getField(input int off, input int nb);
    logic [63:0] v = '0;
    for (int k = 0; k < nb; k++) v = (v << 8) | 64'(msg[off + k]);
    return v;
  endfunction

  task automatic putField(input int off, input int nb, input logic [63:0] val);
    for (int k = 0; k < nb; k++)
      if (off + k < msg.size()) msg[off + k] = 8'(val >> (8 * (nb - 1 - k)));
  endtask

  task automatic buildMsg(input logic [7:0] t, input int n, input logic [15:0] loc,
                          input logic [63:0] rf, input logic [7:0] side,
                          input logic [31:0] sh, input logic [31:0] pr);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    msg[0] = t;
    putField(1, 2, 64'(loc));
    putField(11, 8, rf);
    if (t == 8'h41) begin
      putField(19, 1, 64'(side));
      putField(20, 4, 64'(sh));
      putField(32, 4, 64'(pr));
    end else if (t == 8'h45) begin
      putField(19, 4, 64'(sh));
    end
  endtask

  task automatic checkOutputs(input string tag, input logic [3:0] expPulses);
    checkVal({tag, ".pulses"}, 64'({addValidOut, delValidOut, execValidOut, errOut}), 64'(expPulses));
    checkVal({tag, ".locate"}, 64'(locateOut), 64'(expLocate));
    checkVal({tag, ".ref"}, refNumOut, expRef);
    checkVal({tag, ".price"}, 64'(priceOut), 64'(expPrice));
    checkVal({tag, ".shares"}, 64'(sharesOut), 64'(expShares));
    checkVal({tag, ".side"}, 64'(buySellOut), 64'(expSide));
  endtask

  // Reference: outcome is decided only by type byte and total message length.
  task automatic checkResult(input string tag);
    int unsigned len;
    logic [3:0]  pulses = 4'b0000;
    len = (msg[0] == 8'h41) ? 36 : (msg[0] == 8'h44) ? 19 : (msg[0] == 8'h45) ? 31 : 0;
    if (len != 0) begin
      if (msg.size() == len) begin
        expMsgCnt++;
        expLocate = 16'(getField(1, 2));
        expRef    = getField(11, 8);
        if (msg[0] == 8'h41) begin
          pulses    = 4'b1000;
          expSide   = (msg[19] == 8'h42);
          expShares = 32'(getField(20, 4));
          expPrice  = 32'(getField(32, 4));
        end else if (msg[0] == 8'h44) begin
          pulses = 4'b0100;
        end else begin
          pulses    = 4'b0010;
          expShares = 32'(getField(19, 4));
        end
      end else begin
        pulses = 4'b0001;
        expErrCnt++;
      end
    end
    checkOutputs(tag, pulses);
  endtask

  task automatic quietCycle();
    @(negedge clkIn);
    validIn = 1'b0;
    lastIn  = 1'($urandom);
    dataIn  = 8'($urandom);
    @(posedge clkIn); #1;
    checkVal("quiet.pulses", 64'({addValidOut, delValidOut, execValidOut, errOut}), 64'(0));
  endtask

  task automatic sendMsg(input string tag, input int gapPct, input int nGapsForced);
    int gapsLeft = nGapsForced;
    for (int i = 0; i < msg.size(); i++) begin
      if (i > 0 && ((gapsLeft > 0 && i % 5 == 0) || ($urandom_range(99) < gapPct))) begin
        if (gapsLeft > 0) gapsLeft--;
        quietCycle();
      end
      @(negedge clkIn);
      validIn = 1'b1;
      dataIn  = msg[i];
      lastIn  = (i == msg.size() - 1);
      @(posedge clkIn); #1;
      if (i < msg.size() - 1)
        checkVal({tag, ".mid"}, 64'({addValidOut, delValidOut, execValidOut, errOut}), 64'(0));
      else
        checkResult(tag);
    end
  endtask

  initial begin
    logic [7:0] t;
    int n, sel;
    rstNIn = 1'b0; validIn = 1'b0; lastIn = 1'b0; dataIn = '0;
    modelReset();
    repeat (2) @(posedge clkIn);
    #1 checkOutputs("reset", 4'b0000);
    checkVal("reset.msgCnt", 64'(msgCntOut), 64'(0));
    @(negedge clkIn) rstNIn = 1'b1;

    buildMsg(8'h41, 36, 16'h0007, 64'h1234, 8'h42, 32'd100, 32'h0001E240);
    sendMsg("addDirected", 0, 0);
    checkVal("add.side", 64'(buySellOut), 64'(1));
    checkVal("add.price", 64'(priceOut), 64'h1E240);
    quietCycle();

    buildMsg(8'h44, 19, 16'h0009, 64'h1234, 8'h00, 32'd0, 32'd0);
    sendMsg("delGaps", 0, 3);
    checkVal("del.priceHeld", 64'(priceOut), 64'h1E240);

    buildMsg(8'h45, 26, 16'h0003, 64'h55, 8'h00, 32'd7, 32'd0);
    sendMsg("execShort", 0, 0);
    buildMsg(8'h45, 31, 16'h0003, 64'h56, 8'h00, 32'd50, 32'd0);
    sendMsg("execGood", 0, 0);
    checkVal("exec.shares", 64'(sharesOut), 64'd50);

    buildMsg(8'h41, 40, 16'h0001, 64'h99, 8'h53, 32'd1, 32'd2);
    sendMsg("addLong", 20, 0);
    buildMsg(8'h50, 44, 16'h0001, 64'h98, 8'h00, 32'd0, 32'd0);
    sendMsg("otherType", 0, 0);

    // Reset mid-way through an Add, then a clean Delete.
    buildMsg(8'h41, 36, 16'h0abc, 64'h777, 8'h42, 32'd9, 32'd9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clkIn);
      validIn = 1'b1; dataIn = msg[i]; lastIn = 1'b0;
    end
    @(negedge clkIn);
    validIn = 1'b0;
    rstNIn = 1'b0;
    modelReset();
    #1 checkOutputs("midReset", 4'b0000);
    checkVal("midReset.errCnt", 64'(errCntOut), 64'(0));
    @(negedge clkIn) rstNIn = 1'b1;
    buildMsg(8'h44, 19, 16'h0042, 64'hDEADBEEF01, 8'h00, 32'd0, 32'd0);
    sendMsg("delAfterReset", 0, 0);

    for (int m = 0; m < 40; m++) begin
      sel = $urandom_range(3);
      t = (sel == 0) ? 8'h41 : (sel == 1) ? 8'h44 : (sel == 2) ? 8'h45 : 8'h50 + 8'($urandom_range(40));
      n = (t == 8'h41) ? 36 : (t == 8'h44) ? 19 : (t == 8'h45) ? 31 : 1 + $urandom_range(43);
      if (sel < 3) begin
        if ($urandom_range(3) == 0) n = 2 + $urandom_range(n - 3);
        else if ($urandom_range(4) == 0) n = n + 1 + $urandom_range(5);
      end
      buildMsg(t, n, 16'($urandom), {32'($urandom), 32'($urandom)}, 8'($urandom_range(1) ? 8'h42 : 8'h53),
               32'($urandom), 32'($urandom));
      sendMsg("rand", 15, 0);
      if ($urandom_range(3) == 0) quietCycle();
    end

    quietCycle();
    quietCycle();
`ifdef ITCH_PARSER_STATS_EN
    checkVal("msgCnt", 64'(msgCntOut), 64'(expMsgCnt));
    checkVal("errCnt", 64'(errCntOut), 64'(expErrCnt));
`else
    checkVal("msgCnt", 64'(msgCntOut), 64'(0));
    checkVal("errCnt", 64'(errCntOut), 64'(0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
